conv_window_accumulator: RTL

- Sequential accumulation stage placed directly downstream of the CNN adder datapath.
- Consumes a stream of signed partial products or partial sums, one per handshake, and adds exactly LEN terms per convolution window.
- Emits one saturated window sum per window with a valid/ready handshake toward the activation/pooling stage.
- Accumulation runs at one term per cycle; the output is registered.

---
 rtl/conv_window_accumulator.sv | 122 ++++++++++++
 1 files changed

// File: rtl/conv_window_accumulator.sv
// Window accumulator for the CNN adder datapath: sums LEN signed terms with
// per-addition saturation and hands one registered result downstream.
module conv_window_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN        = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_overflow
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic                 sat_reg, sat_next;
  logic [ACC_WIDTH-1:0] out_data_reg, out_data_next;
  logic                 out_overflow_reg, out_overflow_next;
  logic                 out_valid_reg, out_valid_next;

  logic [ACC_WIDTH:0]   term_ext;
  logic [ACC_WIDTH:0]   acc_ext;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] sum_clamped;
  logic                 sum_sat;
  logic                 accept;
  logic                 last_term;

  // Both operands widened by one bit so the raw sum can never wrap.
  genvar gi;
  generate
    for (gi = 0; gi <= ACC_WIDTH; gi++) begin : g_ext
      if (gi < DATA_WIDTH) begin : g_data
        assign term_ext[gi] = in_data[gi];
      end else begin : g_sign
        assign term_ext[gi] = in_data[DATA_WIDTH-1];
      end
      if (gi < ACC_WIDTH) begin : g_acc
        assign acc_ext[gi] = acc_reg[gi];
      end else begin : g_acc_sign
        assign acc_ext[gi] = acc_reg[ACC_WIDTH-1];
      end
    end
  endgenerate

  assign sum_wide = acc_ext + term_ext;

  // Top two bits disagree exactly when the sum left the ACC_WIDTH range.
  always_comb begin
    sum_sat     = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    sum_clamped = sum_wide[ACC_WIDTH-1:0];
    if (sum_sat) begin
      sum_clamped = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
  end

  assign in_ready  = !out_valid_reg || out_ready;
  assign accept    = in_valid && in_ready;
  assign last_term = (cnt_reg == CNT_LAST);

  always_comb begin
    acc_next          = acc_reg;
    cnt_next          = cnt_reg;
    sat_next          = sat_reg;
    out_data_next     = out_data_reg;
    out_overflow_next = out_overflow_reg;
    out_valid_next    = out_valid_reg;

    if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    // A final term may land in the same cycle the old result drains.
    if (accept) begin
      if (last_term) begin
        out_data_next     = sum_clamped;
        out_overflow_next = sat_reg | sum_sat;
        out_valid_next    = 1'b1;
        acc_next          = '0;
        cnt_next          = '0;
        sat_next          = 1'b0;
      end else begin
        acc_next = sum_clamped;
        cnt_next = cnt_reg + CNT_W'(1);
        sat_next = sat_reg | sum_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_reg          <= '0;
      cnt_reg          <= '0;
      sat_reg          <= 1'b0;
      out_data_reg     <= '0;
      out_overflow_reg <= 1'b0;
      out_valid_reg    <= 1'b0;
    end else begin
      acc_reg          <= acc_next;
      cnt_reg          <= cnt_next;
      sat_reg          <= sat_next;
      out_data_reg     <= out_data_next;
      out_overflow_reg <= out_overflow_next;
      out_valid_reg    <= out_valid_next;
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_data     = out_data_reg;
  assign out_overflow = out_overflow_reg;

endmodule
